// File: rtl/nne_pkg.sv
// rtl/nne_pkg.sv - shared CNN pipeline types, defaults and width helpers
package nne_pkg;

    localparam int DEFAULT_DATA_WIDHT = 32;
    localparam int DEFAULT_CHANNELS   = 8;

    typedef logic signed [DEFAULT_DATA_WIDHT-1:0] sample_t;

    // Counter width for a range of n values, never narrower than one bit
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/max3_signed.sv
// rtl/max3_signed.sv - combinational signed maximum of three operands
module max3_signed
    import nne_pkg::*;
#(
    parameter int W = DEFAULT_DATA_WIDHT
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic signed [W-1:0] c,
    output logic signed [W-1:0] y
);

    logic signed [W-1:0] ab;

    // Pairwise reduction; ties may pick either side since the values are equal
    always_comb begin
        ab = (a > b) ? a : b;
        y  = (ab > c) ? ab : c;
    end

endmodule

// File: rtl/maxpool2x2_layer.sv
// rtl/maxpool2x2_layer.sv - streaming 2x2/stride-2 max-pool, optional fused ReLU via MAXPOOL_RELU_EN
module maxpool2x2_layer
    import nne_pkg::*;
#(
    parameter int DATA_WIDHT = DEFAULT_DATA_WIDHT,
    parameter int CHANNELS   = DEFAULT_CHANNELS,
    parameter int IMG_WIDTH  = 46,
    parameter int IMG_HEIGHT = 46
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDHT*CHANNELS-1:0] Data_In,
    input  logic                           Valid_In,
    output logic [DATA_WIDHT*CHANNELS-1:0] Data_Out,
    output logic                           Valid_Out,
    output logic                           Frame_Done
);

    localparam int PW       = DATA_WIDHT * CHANNELS;
    localparam int CW       = clog2_min1(IMG_WIDTH);
    localparam int RW       = clog2_min1(IMG_HEIGHT);
    localparam int LB_DEPTH = IMG_WIDTH / 2;
    localparam int LBW      = clog2_min1(LB_DEPTH);

    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic [PW-1:0]  h;
    logic [PW-1:0]  lb [LB_DEPTH];
    logic [LBW-1:0] lb_idx;
    logic [PW-1:0]  lb_rd;
    logic [PW-1:0]  pooled;
    logic [PW-1:0]  out_next;
    logic           col_last;
    logic           row_last;
    logic           win_last;

    assign lb_idx   = LBW'(col >> 1);
    assign lb_rd    = lb[lb_idx];
    assign col_last = (col == CW'(IMG_WIDTH - 1));
    assign row_last = (row == RW'(IMG_HEIGHT - 1));
    // Bottom-right pixel of the last complete window; odd trailing row/column are skipped
    assign win_last = (col == CW'(2 * (IMG_WIDTH / 2) - 1)) &&
                      (row == RW'(2 * (IMG_HEIGHT / 2) - 1));

    // One max3 per channel: on even rows the line-buffer operand is replaced by the
    // most negative value so the same comparator yields max(h, Data_In)
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        logic signed [DATA_WIDHT-1:0] c_op;
        logic signed [DATA_WIDHT-1:0] y;

        assign c_op = row[0] ? lb_rd[ch*DATA_WIDHT +: DATA_WIDHT]
                             : {1'b1, {(DATA_WIDHT-1){1'b0}}};

        max3_signed #(.W(DATA_WIDHT)) u_max (
            .a (h[ch*DATA_WIDHT +: DATA_WIDHT]),
            .b (Data_In[ch*DATA_WIDHT +: DATA_WIDHT]),
            .c (c_op),
            .y (y)
        );

        assign pooled[ch*DATA_WIDHT +: DATA_WIDHT] = y;
`ifdef MAXPOOL_RELU_EN
        assign out_next[ch*DATA_WIDHT +: DATA_WIDHT] = y[DATA_WIDHT-1] ? '0 : y;
`else
        assign out_next[ch*DATA_WIDHT +: DATA_WIDHT] = y;
`endif
    end

    // Raster position counters, advanced only by accepted pixels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (Valid_In) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Horizontal register holds the left pixel of the current column pair
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= '0;
        end else if (Valid_In && !col[0]) begin
            h <= Data_In;
        end
    end

    // Line buffer keeps the top-row pair maximum until the matching odd row arrives
    always_ff @(posedge clk) begin
        if (Valid_In && col[0] && !row[0]) begin
            lb[lb_idx] <= pooled;
        end
    end

    // Output register: one pulse per completed window, data held between windows
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Data_Out   <= '0;
            Valid_Out  <= 1'b0;
            Frame_Done <= 1'b0;
        end else begin
            Valid_Out  <= 1'b0;
            Frame_Done <= 1'b0;
            if (Valid_In && col[0] && row[0]) begin
                Data_Out   <= out_next;
                Valid_Out  <= 1'b1;
                Frame_Done <= win_last;
            end
        end
    end

endmodule

// File: tb/tb_maxpool2x2_layer.sv
// tb/tb_maxpool2x2_layer.sv - scoreboard bench for maxpool2x2_layer at three geometries
module tb_maxpool2x2_layer;

    typedef struct {
        logic [255:0] data;
        logic         fd;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [63:0]  a_din, a_dout;
    logic         a_vin, a_vout, a_fd;
    logic [63:0]  b_din, b_dout;
    logic         b_vin, b_vout, b_fd;
    logic [255:0] c_din, c_dout;
    logic         c_vin, c_vout, c_fd;

    maxpool2x2_layer #(.DATA_WIDHT(32), .CHANNELS(2), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
        .clk(clk), .rst(rst), .Data_In(a_din), .Valid_In(a_vin),
        .Data_Out(a_dout), .Valid_Out(a_vout), .Frame_Done(a_fd));

    maxpool2x2_layer #(.DATA_WIDHT(32), .CHANNELS(2), .IMG_WIDTH(5), .IMG_HEIGHT(5)) dut_b (
        .clk(clk), .rst(rst), .Data_In(b_din), .Valid_In(b_vin),
        .Data_Out(b_dout), .Valid_Out(b_vout), .Frame_Done(b_fd));

    maxpool2x2_layer #(.DATA_WIDHT(32), .CHANNELS(8), .IMG_WIDTH(46), .IMG_HEIGHT(46)) dut_c (
        .clk(clk), .rst(rst), .Data_In(c_din), .Valid_In(c_vin),
        .Data_Out(c_dout), .Valid_Out(c_vout), .Frame_Done(c_fd));

    int   img [8][46][46];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   a_nout = 0, a_nfd = 0, b_nout = 0, b_nfd = 0, c_nout = 0, c_nfd = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference 2x2 maximum over img with top-left corner (r, c)
    function automatic logic [31:0] pool4(input int ch, input int r, input int c);
        int m;
        m = img[ch][r][c];
        if (img[ch][r][c+1]   > m) m = img[ch][r][c+1];
        if (img[ch][r+1][c]   > m) m = img[ch][r+1][c];
        if (img[ch][r+1][c+1] > m) m = img[ch][r+1][c+1];
`ifdef MAXPOOL_RELU_EN
        if (m < 0) m = 0;
`endif
        return m;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one raster frame to DUT 'which'; stops before pixel index stop_at (-1 = whole frame)
    task automatic drive_frame(input int which, input int w, input int h, input int nch,
                               input int max_gap, input int stop_at);
        logic [255:0] word;
        exp_t         e;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (r * w + c == stop_at) begin
                    a_vin = 1'b0; b_vin = 1'b0; c_vin = 1'b0;
                    return;
                end
                if (max_gap > 0) begin
                    a_vin = 1'b0; b_vin = 1'b0; c_vin = 1'b0;
                    idle($urandom_range(0, max_gap));
                end
                word = '0;
                for (int ch = 0; ch < nch; ch++) word[ch*32 +: 32] = img[ch][r][c];
                if ((r % 2 == 1) && (c % 2 == 1) && (r < 2 * (h / 2)) && (c < 2 * (w / 2))) begin
                    e.data = '0;
                    for (int ch = 0; ch < nch; ch++) e.data[ch*32 +: 32] = pool4(ch, r - 1, c - 1);
                    e.fd  = (r == 2 * (h / 2) - 1) && (c == 2 * (w / 2) - 1);
                    e.cyc = cyc + 1;
                    case (which)
                        0:       q_a.push_back(e);
                        1:       q_b.push_back(e);
                        default: q_c.push_back(e);
                    endcase
                end
                case (which)
                    0:       begin a_din = word[63:0]; a_vin = 1'b1; end
                    1:       begin b_din = word[63:0]; b_vin = 1'b1; end
                    default: begin c_din = word;       c_vin = 1'b1; end
                endcase
                @(posedge clk);
                #1;
            end
        end
        a_vin = 1'b0; b_vin = 1'b0; c_vin = 1'b0;
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                img[0][r][c] = r * 4 + c;
                img[1][r][c] = -(r * 4 + c);
            end
    endtask

    // Output monitors: pop the scoreboard on every Valid_Out
    always @(negedge clk) begin
        exp_t e;
        if (a_vout) begin
            a_nout++;
            if (a_fd) a_nfd++;
            if (q_a.size() == 0) check("a_unexpected_out", a_vout, 1'b0);
            else begin
                e = q_a.pop_front();
                check("a_data", a_dout, e.data);
                check("a_frame_done", a_fd, e.fd);
                check("a_latency", cyc, e.cyc);
            end
        end else if (a_fd) check("a_fd_alone", a_fd, 1'b0);
    end

    always @(negedge clk) begin
        exp_t e;
        if (b_vout) begin
            b_nout++;
            if (b_fd) b_nfd++;
            if (q_b.size() == 0) check("b_unexpected_out", b_vout, 1'b0);
            else begin
                e = q_b.pop_front();
                check("b_data", b_dout, e.data);
                check("b_frame_done", b_fd, e.fd);
                check("b_latency", cyc, e.cyc);
            end
        end else if (b_fd) check("b_fd_alone", b_fd, 1'b0);
    end

    always @(negedge clk) begin
        exp_t e;
        if (c_vout) begin
            c_nout++;
            if (c_fd) c_nfd++;
            if (q_c.size() == 0) check("c_unexpected_out", c_vout, 1'b0);
            else begin
                e = q_c.pop_front();
                check("c_data", c_dout, e.data);
                check("c_frame_done", c_fd, e.fd);
                check("c_latency", cyc, e.cyc);
            end
        end else if (c_fd) check("c_fd_alone", c_fd, 1'b0);
    end

    initial begin
        rst = 1'b1;
        a_vin = 1'b0; b_vin = 1'b0; c_vin = 1'b0;
        a_din = '0;   b_din = '0;   c_din = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_a_dout", a_dout, '0);
        check("reset_a_vout", a_vout, 1'b0);
        check("reset_a_fd", a_fd, 1'b0);
        check("reset_b_dout", b_dout, '0);
        check("reset_c_dout", c_dout, '0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Ramp frame, no gaps
        fill_ramp();
        a_nout = 0; a_nfd = 0;
        drive_frame(0, 4, 4, 2, 0, -1);
        idle(4);
        check("t1_outputs", a_nout, 4);
        check("t1_frame_done", a_nfd, 1);
        check("t1_pending", q_a.size(), 0);

        // Same frame with random idle gaps
        a_nout = 0; a_nfd = 0;
        drive_frame(0, 4, 4, 2, 3, -1);
        idle(4);
        check("t2_outputs", a_nout, 4);
        check("t2_frame_done", a_nfd, 1);
        check("t2_pending", q_a.size(), 0);

        // Odd geometry, all-ones samples, two back-to-back frames
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                img[0][r][c] = -1;
                img[1][r][c] = -1;
            end
        b_nout = 0; b_nfd = 0;
        drive_frame(1, 5, 5, 2, 0, -1);
        drive_frame(1, 5, 5, 2, 0, -1);
        idle(4);
        check("t3_outputs", b_nout, 8);
        check("t3_frame_done", b_nfd, 2);
        check("t3_pending", q_b.size(), 0);

        // All-negative first window
        fill_ramp();
        img[0][0][0] = -3; img[0][0][1] = -7; img[0][1][0] = -1; img[0][1][1] = -9;
        img[1][0][0] = -3; img[1][0][1] = -7; img[1][1][0] = -1; img[1][1][1] = -9;
        a_nout = 0; a_nfd = 0;
        drive_frame(0, 4, 4, 2, 0, -1);
        idle(4);
        check("t4_outputs", a_nout, 4);
        check("t4_pending", q_a.size(), 0);

        // Reset mid-frame at pixel (1,3), then a fresh frame
        fill_ramp();
        a_nout = 0; a_nfd = 0;
        drive_frame(0, 4, 4, 2, 0, 7);
        a_din = {img[1][1][3], img[0][1][3]};
        a_vin = 1'b1;
        rst   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t6_rst_dout", a_dout, '0);
            check("t6_rst_vout", a_vout, 1'b0);
            check("t6_rst_fd", a_fd, 1'b0);
        end
        @(posedge clk);
        #1;
        a_vin = 1'b0;
        rst   = 1'b0;
        idle(2);
        check("t6_outputs_before_abort", a_nout, 1);
        drive_frame(0, 4, 4, 2, 0, -1);
        idle(4);
        check("t6_outputs_total", a_nout, 5);
        check("t6_frame_done", a_nfd, 1);
        check("t6_pending", q_a.size(), 0);

        // Full-size frame against the reference pool
        for (int ch = 0; ch < 8; ch++)
            for (int r = 0; r < 46; r++)
                for (int c = 0; c < 46; c++)
                    img[ch][r][c] = $urandom;
        c_nout = 0; c_nfd = 0;
        drive_frame(2, 46, 46, 8, 0, -1);
        idle(4);
        check("t5_outputs", c_nout, 529);
        check("t5_frame_done", c_nfd, 1);
        check("t5_pending", q_c.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
